// File: rtl/seq_muldiv_unit.sv
// Multi-cycle signed MUL/MUH/DIV/MOD unit: shift-add multiply and restoring divide,
// one bit per cycle over operand magnitudes, sign fixed up when the result loads.
package seq_muldiv_pkg;
    localparam int DataWidth = 16;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_MUL = 3'd4,
        OP_MUH = 3'd5,
        OP_DIV = 3'd6,
        OP_MOD = 3'd7
    } eOperation;

    typedef struct packed {
        logic Carry;
        logic NoCarry;
        logic Zero;
        logic NotZero;
        logic Negative;
        logic Parity;
        logic Overflow;
        logic Always;
    } sFlags;
endpackage

// Handshake: Start is sampled only while not Busy (IDLE or DONE); Done pulses for one
// cycle when OutDest/OutFlags/DivByZero update, and Busy is never high together with Done.
module seq_muldiv_unit
    import seq_muldiv_pkg::*;
#(
    parameter int Width = DataWidth
) (
    input  logic                    Clock,
    input  logic                    nReset,
    input  logic                    Start,
    input  eOperation               Operation,
    input  logic signed [Width-1:0] InDest,
    input  logic signed [Width-1:0] InSrc,
    input  sFlags                   InFlags,
    output logic                    Busy,
    output logic                    Done,
    output logic                    DivByZero,
    output logic signed [Width-1:0] OutDest,
    output sFlags                   OutFlags,
    output logic [1:0]              DebugState
);

    localparam int CW = $clog2(Width + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    eOperation           op_q, op_d;
    sFlags               flags_q, flags_d;
    logic [Width-1:0]    mag_q, mag_d;
    logic [2*Width-1:0]  acc_q, acc_d;
    logic                neg_q, neg_d;
    logic                ovf_q, ovf_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                dbz_q, dbz_d;
    logic [Width-1:0]    out_dest_q, out_dest_d;
    sFlags               out_flags_q, out_flags_d;

    logic [Width-1:0]    a_mag, b_mag;
    logic                is_mul, is_div;
    logic [Width:0]      add_sum;
    logic [Width:0]      rem_sh;
    logic [Width:0]      diff;
    logic [2*Width-1:0]  prod;
    logic [Width-1:0]    result;
    logic [Width-1:0]    imm_result;

    function automatic sFlags make_flags(input sFlags f, input logic [Width-1:0] r,
                                         input logic ovf);
        sFlags o;
        o          = f;
        o.Zero     = (r == '0);
        o.NotZero  = (r != '0);
        o.Negative = r[Width-1];
        o.Parity   = ~^r;
        o.Overflow = ovf;
        o.Always   = 1'b1;
        return o;
    endfunction

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        flags_d     = flags_q;
        mag_d       = mag_q;
        acc_d       = acc_q;
        neg_d       = neg_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        out_dest_d  = out_dest_q;
        out_flags_d = out_flags_q;

        a_mag  = InDest[Width-1] ? ('0 - $unsigned(InDest)) : $unsigned(InDest);
        b_mag  = InSrc[Width-1]  ? ('0 - $unsigned(InSrc))  : $unsigned(InSrc);
        is_mul = (Operation == OP_MUL) || (Operation == OP_MUH);
        is_div = (Operation == OP_DIV) || (Operation == OP_MOD);
        imm_result = (Operation == OP_DIV) ? '1 : $unsigned(InDest);

        add_sum = acc_q[0] ? ({1'b0, acc_q[2*Width-1:Width]} + {1'b0, mag_q})
                           : {1'b0, acc_q[2*Width-1:Width]};
        rem_sh  = acc_q[2*Width-1:Width-1];
        diff    = rem_sh - {1'b0, mag_q};
        prod    = neg_q ? ('0 - acc_q) : acc_q;

        case (op_q)
            OP_MUL:  result = prod[Width-1:0];
            OP_MUH:  result = prod[2*Width-1:Width];
            OP_DIV:  result = neg_q ? ('0 - acc_q[Width-1:0]) : acc_q[Width-1:0];
            default: result = neg_q ? ('0 - acc_q[2*Width-1:Width]) : acc_q[2*Width-1:Width];
        endcase

        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    op_d    = Operation;
                    flags_d = InFlags;
                    cnt_d   = '0;
                    if (is_mul) begin
                        mag_d   = a_mag;
                        acc_d   = {{Width{1'b0}}, b_mag};
                        neg_d   = InDest[Width-1] ^ InSrc[Width-1];
                        ovf_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_RUN;
                    end else if (is_div && (InSrc != '0)) begin
                        mag_d   = b_mag;
                        acc_d   = {{Width{1'b0}}, a_mag};
                        neg_d   = (Operation == OP_DIV) ? (InDest[Width-1] ^ InSrc[Width-1])
                                                        : InDest[Width-1];
                        // Only -2^(W-1) / -1 overflows; its quotient magnitude already wraps correctly.
                        ovf_d   = (Operation == OP_DIV) && (InSrc == '1) &&
                                  (InDest == {1'b1, {(Width-1){1'b0}}});
                        busy_d  = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        dbz_d       = is_div;
                        out_dest_d  = is_div ? imm_result : '0;
                        out_flags_d = is_div ? make_flags(InFlags, imm_result, InFlags.Overflow)
                                             : InFlags;
                        done_d      = 1'b1;
                        state_d     = S_DONE;
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt_q == CW'(Width)) begin
                    out_dest_d  = result;
                    out_flags_d = make_flags(flags_q, result, ovf_q | flags_q.Overflow);
                    dbz_d       = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if ((op_q == OP_MUL) || (op_q == OP_MUH)) begin
                        acc_d = {add_sum, acc_q[Width-1:1]};
                    end else if (!diff[Width]) begin
                        acc_d = {diff[Width-1:0], acc_q[Width-2:0], 1'b1};
                    end else begin
                        acc_d = {rem_sh[Width-1:0], acc_q[Width-2:0], 1'b0};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_ADD;
            flags_q     <= '0;
            mag_q       <= '0;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            out_dest_q  <= '0;
            out_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            flags_q     <= flags_d;
            mag_q       <= mag_d;
            acc_q       <= acc_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
            out_dest_q  <= out_dest_d;
            out_flags_q <= out_flags_d;
        end
    end

    assign Busy       = busy_q;
    assign Done       = done_q;
    assign DivByZero  = dbz_q;
    assign OutDest    = out_dest_q;
    assign OutFlags   = out_flags_q;
    assign DebugState = state_q;

endmodule
